cc_miss_issue_unit: RTL and testbench
=====================================

CC_MISS_ISSUE_UNIT -- requirements
Module: CC_MISS_ISSUE_UNIT

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max AR bursts issued but not yet completed by an R-channel last beat (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port miss_req_i  input  1  tag-compare stage reports a read miss.
REQ-005 SHALL have port miss_addr_i  input  32  byte address of the missing word.
REQ-006 SHALL have port miss_ack_o  output  1  miss accepted this cycle when high with miss_req_i.
REQ-007 SHALL have ports mem_arvalid_o output 1, mem_arready_i input 1, mem_araddr_o output 32, mem_arlen_o output 4, mem_arsize_o output 3, mem_arburst_o output 2: AXI AR channel to MEM.
REQ-008 SHALL have ports mem_rvalid_i, mem_rready_i, mem_rlast_i  input  1 each  R-channel monitor, used only to retire bursts.
REQ-009 SHALL have ports miss_addr_fifo_full_i input 1, miss_addr_fifo_wren_o output 1, miss_addr_fifo_wdata_o output 32: write side of the miss-address FIFO drained by the data fill unit.
REQ-010 SHALL have port outstanding_o  output  4  current outstanding-burst count.

Function
REQ-011 SHALL implement FSM states IDLE and ISSUE.
REQ-012 miss_ack_o SHALL equal (state==IDLE) & !miss_addr_fifo_full_i & (outstanding < MAX_OUTSTANDING), with no dependence on miss_req_i.
REQ-013 On miss_req_i & miss_ack_o in cycle N, miss_addr_fifo_wren_o SHALL be 1 in cycle N with miss_addr_fifo_wdata_o = miss_addr_i unmodified (low offset bits kept for critical-word-first fill).
REQ-014 Same accept cycle N: SHALL register araddr = {miss_addr_i[31:3],3'b000} and move to ISSUE; mem_arvalid_o SHALL be 1 from cycle N+1.
REQ-015 miss_addr_fifo_wren_o SHALL be 0 in every cycle without an accept; never asserted while miss_addr_fifo_full_i is 1.
REQ-016 In ISSUE, mem_arvalid_o SHALL stay 1 and mem_araddr_o stable until mem_arready_i is 1; that cycle is the AR handshake.
REQ-017 On AR handshake SHALL return to IDLE and mem_arvalid_o SHALL be 0 next cycle; minimum spacing between two accepts = 2 cycles.
REQ-018 mem_arlen_o SHALL be constant 4'd7 (8 beats), mem_arsize_o constant 3'd3 (8 bytes), mem_arburst_o constant 2'b10 (WRAP).
REQ-019 Outstanding counter SHALL increment on AR handshake and decrement on mem_rvalid_i & mem_rready_i & mem_rlast_i.
REQ-020 Simultaneous increment and decrement SHALL leave the counter unchanged.
REQ-021 Decrement with counter 0 SHALL leave it at 0 (protocol error, no wrap); increment SHALL never exceed MAX_OUTSTANDING by construction of REQ-012.
REQ-022 FIFO push order SHALL equal AR issue order, so the fill unit pops addresses in R-burst return order.
REQ-023 miss_ack_o SHALL be 0 throughout ISSUE regardless of miss_req_i; a pending miss_req_i is held by the requester.

Reset
REQ-024 With rst_n low at a clock edge: state IDLE, mem_arvalid_o 0, araddr register 0, outstanding 0, next cycle miss_addr_fifo_wren_o 0.
REQ-025 Reset asserted in ISSUE SHALL drop mem_arvalid_o next cycle without completing the handshake; no counter update.

Structure
REQ-026 AXI constants (ARLEN_LINE=7, ARSIZE_8B=3, BURST_WRAP=2'b10) and the IDLE/ISSUE state enum SHALL live in shared package CC_PKG, also used by the fill unit.
REQ-027 SHALL be a single module with no sub-module; FSM, address register and counter are inline.

Verification
REQ-028 Miss addr 0x0000_1234, arready high immediately -> fifo write 0x0000_1234 same cycle, arvalid next cycle with araddr 0x0000_1230, len 7, size 3, burst WRAP; outstanding 0->1.
REQ-029 arready held low 5 cycles -> arvalid and araddr stable 5 cycles, miss_ack_o 0 throughout, second miss_req_i not accepted until IDLE.
REQ-030 MAX_OUTSTANDING=2, three misses with no R data -> two issued, third blocked (miss_ack_o 0) until one rlast beat, then accepted.
REQ-031 miss_addr_fifo_full_i 1 with miss_req_i 1 -> no fifo write, no arvalid; deassert full -> accept next cycle.
REQ-032 AR handshake coincident with rlast beat at outstanding 1 -> outstanding stays 1.
REQ-033 rst_n low during ISSUE -> arvalid 0 and outstanding 0 after reset edge; first post-reset miss issues normally.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions used by the miss issue unit and the data fill unit.
// Holds the AXI read-burst constants for one cache line and the issue FSM states.
package cc_pkg;

    // One line is fetched as a single 8-beat, 8-byte, wrapping burst.
    localparam logic [3:0] ARLEN_LINE = 4'd7;
    localparam logic [2:0] ARSIZE_8B  = 3'd3;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } miss_state_e;

endpackage

// File: rtl/cc_miss_issue_unit.sv
// Turns tag-compare read misses into AXI AR line bursts. It also pushes each raw miss address to the fill unit's FIFO.
// It tracks how many bursts are still waiting for their last R beat.
module cc_miss_issue_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ack_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic [3:0]  outstanding_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    miss_state_e state;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [3:0]  outstanding_q;
    logic        accept;
    logic        ar_hs;
    logic        r_done;

    // Ack never looks at miss_req_i so the requester sees a stable ready.
    assign miss_ack_o = (state == IDLE) & ~miss_addr_fifo_full_i & (outstanding_q < MAX_CNT);
    assign accept     = miss_req_i & miss_ack_o;
    assign ar_hs      = arvalid_q & mem_arready_i;
    assign r_done     = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    // The full address, including the word offset, goes to the FIFO so the fill unit can return the critical word first.
    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = miss_addr_i;

    assign mem_arvalid_o = arvalid_q;
    assign mem_araddr_o  = araddr_q;
    assign mem_arlen_o   = ARLEN_LINE;
    assign mem_arsize_o  = ARSIZE_8B;
    assign mem_arburst_o = BURST_WRAP;
    assign outstanding_o = outstanding_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        araddr_q  <= {miss_addr_i[31:3], 3'b000};
                        arvalid_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_arready_i) begin
                        arvalid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // A stray last beat at zero is a protocol error and is absorbed rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            case ({ar_hs, r_done})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   if (outstanding_q != 4'd0) outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_miss_issue_unit.sv
// Bench for cc_miss_issue_unit: directed scenarios followed by randomized traffic.
// Every cycle is compared against a queue-based model of the miss issue rules.
module tb_cc_miss_issue_unit;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        miss_ack;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic        fifo_full;
    logic        fifo_wren;
    logic [31:0] fifo_wdata;
    logic [3:0]  outstanding;

    int total = 0;
    int bad   = 0;

    cc_miss_issue_unit #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_i             (miss_req),
        .miss_addr_i            (miss_addr),
        .miss_ack_o             (miss_ack),
        .mem_arvalid_o          (arvalid),
        .mem_arready_i          (arready),
        .mem_araddr_o           (araddr),
        .mem_arlen_o            (arlen),
        .mem_arsize_o           (arsize),
        .mem_arburst_o          (arburst),
        .mem_rvalid_i           (rvalid),
        .mem_rready_i           (rready),
        .mem_rlast_i            (rlast),
        .miss_addr_fifo_full_i  (fifo_full),
        .miss_addr_fifo_wren_o  (fifo_wren),
        .miss_addr_fifo_wdata_o (fifo_wdata),
        .outstanding_o          (outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one accepted-but-unissued miss, plus a count of bursts awaiting their last beat.
    logic [31:0] pend_q[$];
    int          m_cnt   = 0;
    bit          m_valid = 0;

    function automatic bit m_ack();
        return (pend_q.size() == 0) && !fifo_full && (m_cnt < MAXO);
    endfunction

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            pend_q.delete();
            m_cnt   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            bit hs, ret, acc;
            hs  = (pend_q.size() != 0) && arready;
            ret = rvalid && rready && rlast;
            acc = miss_req && m_ack();
            if (hs) void'(pend_q.pop_front());
            if (hs && !ret) m_cnt++;
            else if (ret && !hs && m_cnt > 0) m_cnt--;
            if (acc) pend_q.push_back(miss_addr);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit a;
            a = m_ack();
            chk("ack", {31'd0, miss_ack}, {31'd0, a});
            chk("wren", {31'd0, fifo_wren}, {31'd0, (miss_req && a)});
            if (miss_req && a) chk("wdata", fifo_wdata, miss_addr);
            chk("arvalid", {31'd0, arvalid}, {31'd0, (pend_q.size() != 0)});
            if (pend_q.size() != 0) chk("araddr", araddr, pend_q[0] & 32'hFFFF_FFF8);
            chk("outstanding", {28'd0, outstanding}, m_cnt);
            chk("arlen", {28'd0, arlen}, 32'd7);
            chk("arsize", {29'd0, arsize}, 32'd3);
            chk("arburst", {30'd0, arburst}, 32'd2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rbeat(input logic v);
        rvalid = v;
        rready = v;
        rlast  = v;
    endtask

    initial begin
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; arready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
        chk("rst_wren", {31'd0, fifo_wren}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        tick();
        rst_n = 1'b1;

        // Basic miss with immediate arready
        miss_req = 1'b1; miss_addr = 32'h0000_1234; arready = 1'b1;
        @(negedge clk);
        chk("d28_wren", {31'd0, fifo_wren}, 32'd1);
        chk("d28_wdata", fifo_wdata, 32'h0000_1234);
        tick();
        miss_req = 1'b0;
        @(negedge clk);
        chk("d28_arvalid", {31'd0, arvalid}, 32'd1);
        chk("d28_araddr", araddr, 32'h0000_1230);
        chk("d28_cnt0", {28'd0, outstanding}, 32'd0);
        tick();
        @(negedge clk);
        chk("d28_arvalid_drop", {31'd0, arvalid}, 32'd0);
        chk("d28_cnt1", {28'd0, outstanding}, 32'd1);
        rbeat(1'b1); tick(); rbeat(1'b0);

        // arready held low; a second miss waits
        arready = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_2008;
        tick();
        miss_addr = 32'h0000_3000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d29_arvalid", {31'd0, arvalid}, 32'd1);
            chk("d29_araddr", araddr, 32'h0000_2008);
            chk("d29_ack", {31'd0, miss_ack}, 32'd0);
            chk("d29_wren", {31'd0, fifo_wren}, 32'd0);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clk);
        chk("d29_ack2", {31'd0, miss_ack}, 32'd1);
        chk("d29_wdata2", fifo_wdata, 32'h0000_3000);
        tick();
        miss_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;

        // Outstanding limit of 2 blocks a third miss until a last beat
        miss_req = 1'b1; miss_addr = 32'h0000_4000;
        @(negedge clk);
        chk("d30_cnt2", {28'd0, outstanding}, 32'd2);
        chk("d30_ack_blk", {31'd0, miss_ack}, 32'd0);
        tick();
        @(negedge clk);
        chk("d30_wren_blk", {31'd0, fifo_wren}, 32'd0);
        rbeat(1'b1);
        tick();
        rbeat(1'b0);
        @(negedge clk);
        chk("d30_ack_open", {31'd0, miss_ack}, 32'd1);
        chk("d30_wren_open", {31'd0, fifo_wren}, 32'd1);
        tick();
        miss_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;

        // Handshake coincident with a last beat at count 1
        rbeat(1'b1); tick(); rbeat(1'b0);
        miss_req = 1'b1; miss_addr = 32'h0000_5000;
        tick();
        miss_req = 1'b0; arready = 1'b1; rbeat(1'b1);
        tick();
        arready = 1'b0; rbeat(1'b0);
        @(negedge clk);
        chk("d32_cnt_hold", {28'd0, outstanding}, 32'd1);
        rbeat(1'b1); tick(); tick(); rbeat(1'b0);
        @(negedge clk);
        chk("d21_no_wrap", {28'd0, outstanding}, 32'd0);

        // FIFO full blocks acceptance
        fifo_full = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_6004;
        @(negedge clk);
        chk("d31_wren_full", {31'd0, fifo_wren}, 32'd0);
        tick();
        @(negedge clk);
        chk("d31_arvalid_full", {31'd0, arvalid}, 32'd0);
        fifo_full = 1'b0;
        @(negedge clk);
        chk("d31_wdata", fifo_wdata, 32'h0000_6004);
        tick();
        miss_req = 1'b0;
        @(negedge clk);
        chk("d31_araddr", araddr, 32'h0000_6000);

        // Reset while an AR is pending
        arready = 1'b1; tick(); arready = 1'b0;
        miss_req = 1'b1; miss_addr = 32'h0000_7000;
        tick();
        miss_req = 1'b0;
        tick();
        rst_n = 1'b0; arready = 1'b1;
        tick();
        rst_n = 1'b1; arready = 1'b0;
        @(negedge clk);
        chk("d33_arvalid", {31'd0, arvalid}, 32'd0);
        chk("d33_cnt", {28'd0, outstanding}, 32'd0);
        miss_req = 1'b1; miss_addr = 32'h0000_8010; arready = 1'b1;
        tick();
        miss_req = 1'b0;
        @(negedge clk);
        chk("d33_araddr", araddr, 32'h0000_8010);
        tick();
        @(negedge clk);
        chk("d33_cnt1", {28'd0, outstanding}, 32'd1);
        arready = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            miss_req  = rst_n && ($urandom_range(0, 9) < 6);
            miss_addr = $urandom;
            arready   = ($urandom_range(0, 1) == 1);
            rvalid    = ($urandom_range(0, 3) != 0);
            rready    = ($urandom_range(0, 3) != 0);
            rlast     = ($urandom_range(0, 2) == 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
